// File: rtl/prof_pkg.sv
// Shared types for the HLS block-level handshake profiler: FSM states and the
// per-invocation record that flows through the record FIFO to the dump consumer.
package prof_pkg;

  localparam int PROF_CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WAIT_CONT
  } prof_state_e;

  typedef struct packed {
    logic [7:0]            mod_id;
    logic                  incomplete;
    logic [PROF_CNT_W-1:0] start;
    logic [PROF_CNT_W-1:0] latency;
    logic [PROF_CNT_W-1:0] interval;
    logic [PROF_CNT_W-1:0] stall;
  } prof_rec_t;

endpackage

// File: rtl/prof_rec_fifo.sv
// First-word-fall-through record FIFO. A pop in the same cycle frees a slot, so a
// push into a full FIFO is still accepted when the head is being consumed.
module prof_rec_fifo
  import prof_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  prof_rec_t push_data,
  input  logic      pop,
  output prof_rec_t head,
  output logic      full,
  output logic      empty,
  output logic      accepted
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  prof_rec_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            pop_ok;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_ok   = pop && !empty;
  assign accepted = push && (!full || pop_ok);
  // Storage is not reset, so mask the head while empty to keep rec_data at 0.
  assign head     = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (accepted) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accepted) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)   rd_ptr <= rd_ptr + AW'(1);
      unique case ({accepted, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ap_handshake_profiler.sv
// Per-kernel profiler: tracks ap_start/ap_done/ap_continue, turns each invocation
// into a record {start, latency, interval, stall} and queues it for the dump path.
module ap_handshake_profiler
  import prof_pkg::*;
#(
  parameter int         CNT_W  = PROF_CNT_W,
  parameter int         DEPTH  = 8,
  parameter logic [7:0] MOD_ID = 8'd0
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             enable,
  input  logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_continue,
  input  logic             finish,
  output logic             rec_valid,
  input  logic             rec_ready,
  output prof_rec_t        rec_data,
  output logic             busy,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_count,
  output logic [CNT_W-1:0] cycle_count
);

  prof_state_e      state;
  logic [CNT_W-1:0] s_q, lat_q, int_q, stall_q;
  logic             prev_valid, start_blk;
  logic             start_ok, flush, complete, push, restart;
  logic             fifo_full, fifo_empty, push_ok;
  logic [CNT_W-1:0] cur_lat, new_int;
  prof_rec_t        rec;
  logic             unused_ready;

  // ap_ready carries no information the record needs.
  assign unused_ready = ap_ready;
  assign busy         = (state != IDLE);
  assign rec_valid    = !fifo_empty;

  always_comb begin
    start_ok       = ap_start && enable && !(start_blk && finish);
    cur_lat        = cycle_count - s_q + CNT_W'(1);
    new_int        = prev_valid ? cycle_count - s_q : '0;
    flush          = (state != IDLE) && finish;
    complete       = 1'b0;
    rec            = '0;
    rec.mod_id     = MOD_ID;
    rec.incomplete = flush;
    rec.start      = s_q;
    rec.latency    = cur_lat;
    rec.interval   = int_q;
    rec.stall      = '0;
    unique case (state)
      IDLE: begin
        complete     = start_ok && ap_done && ap_continue;
        rec.start    = cycle_count;
        rec.latency  = CNT_W'(1);
        rec.interval = new_int;
      end
      RUN:       complete = !finish && ap_done && ap_continue;
      WAIT_CONT: begin
        complete  = !finish && ap_continue;
        rec.stall = stall_q;
        if (!finish) rec.latency = lat_q;
      end
      default: complete = 1'b0;
    endcase
    push    = complete || flush;
    restart = complete && (state != IDLE) && start_ok;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state      <= IDLE;
      s_q        <= '0;
      lat_q      <= '0;
      int_q      <= '0;
      stall_q    <= '0;
      prev_valid <= 1'b0;
      start_blk  <= 1'b0;
    end else begin
      if (!finish) start_blk <= 1'b0;
      unique case (state)
        IDLE: if (start_ok) begin
          s_q        <= cycle_count;
          int_q      <= new_int;
          prev_valid <= 1'b1;
          if (!ap_done) begin
            state <= RUN;
          end else if (!ap_continue) begin
            state   <= WAIT_CONT;
            lat_q   <= CNT_W'(1);
            stall_q <= CNT_W'(1);
          end
        end
        RUN: begin
          if (finish) begin
            state     <= IDLE;
            start_blk <= 1'b1;
          end else if (ap_done && !ap_continue) begin
            state   <= WAIT_CONT;
            lat_q   <= cur_lat;
            stall_q <= CNT_W'(1);   // the done cycle itself is the first stalled cycle
          end else if (ap_done) begin
            state <= IDLE;
          end
        end
        WAIT_CONT: begin
          if (finish) begin
            state     <= IDLE;
            start_blk <= 1'b1;
          end else if (ap_continue) begin
            state <= IDLE;
          end else if (stall_q != '1) begin
            stall_q <= stall_q + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
      // Back-to-back: a start seen in the completion cycle opens the next invocation.
      if (restart) begin
        state <= RUN;
        s_q   <= cycle_count;
        int_q <= new_int;
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cycle_count <= '0;
      overflow    <= 1'b0;
      drop_count  <= '0;
    end else begin
      cycle_count <= cycle_count + CNT_W'(1);
      if (push && !push_ok) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + CNT_W'(1);
      end
    end
  end

  prof_rec_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (ap_clk),
    .rst_n     (ap_rst_n),
    .push      (push),
    .push_data (rec),
    .pop       (rec_ready),
    .head      (rec_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .accepted  (push_ok)
  );

endmodule

// File: tb/tb_ap_handshake_profiler.sv
// Bench for ap_handshake_profiler: directed test-plan scenarios then random traffic,
// checked by a reference model feeding an expected-record queue and a negedge monitor.
module tb_ap_handshake_profiler;
  import prof_pkg::*;

  localparam int         DEPTH = 4;
  localparam logic [7:0] MODID = 8'h5A;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        enable = 1'b0, ap_start = 1'b0, ap_ready = 1'b0, ap_done = 1'b0;
  logic        ap_continue = 1'b1, finish = 1'b0, rec_ready = 1'b0;
  logic        rec_valid, busy, overflow;
  prof_rec_t   rec_data;
  logic [31:0] drop_count, cycle_count;

  always #5 ap_clk = ~ap_clk;

  ap_handshake_profiler #(.CNT_W(32), .DEPTH(DEPTH), .MOD_ID(MODID)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .enable(enable), .ap_start(ap_start),
    .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_data(rec_data), .busy(busy),
    .overflow(overflow), .drop_count(drop_count), .cycle_count(cycle_count)
  );

  int          checks = 0;
  int          errors = 0;
  prof_rec_t   exp_q[$];
  prof_rec_t   got_q[$];
  logic [31:0] cyc = '0;
  bit          mon_en = 1'b0;

  // reference model: invocation bookkeeping plus FIFO occupancy
  bit          m_inflight, m_done_seen, m_prev_valid, m_blk, m_ovf;
  logic [31:0] m_s, m_lat, m_int, m_stall, m_drop;
  int          m_occ;
  bit          busy_now, ovf_now;
  int          occ_now;
  logic [31:0] drop_now;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic prof_rec_t mk(input bit inc, input logic [31:0] s, lat, intv, stl);
    prof_rec_t r;
    r.mod_id = MODID; r.incomplete = inc; r.start = s;
    r.latency = lat; r.interval = intv; r.stall = stl;
    return r;
  endfunction

  task automatic model_reset();
    m_inflight = 0; m_done_seen = 0; m_prev_valid = 0; m_blk = 0; m_ovf = 0;
    m_s = '0; m_lat = '0; m_int = '0; m_stall = '0; m_drop = '0; m_occ = 0;
    busy_now = 0; ovf_now = 0; occ_now = 0; drop_now = '0;
    exp_q.delete();
  endtask

  task automatic begin_inv();
    m_int = m_prev_valid ? cyc - m_s : 32'd0;
    m_s = cyc; m_prev_valid = 1; m_inflight = 1; m_done_seen = 0;
  endtask

  // One cycle of the reference model, using the inputs driven for cycle 'cyc'.
  task automatic model_step();
    bit        pop, have, ended, flushed, can_start;
    prof_rec_t r;
    busy_now = m_inflight; occ_now = m_occ; ovf_now = m_ovf; drop_now = m_drop;
    pop = rec_ready && (m_occ > 0);
    have = 0; ended = 0; flushed = 0; r = '0;
    can_start = ap_start && enable && !(m_blk && finish);
    if (m_inflight) begin
      if (finish) begin
        r = mk(1, m_s, cyc - m_s + 1, m_int, m_done_seen ? m_stall : 32'd0);
        have = 1; m_inflight = 0; flushed = 1;
      end else if (!m_done_seen) begin
        if (ap_done) begin
          m_lat = cyc - m_s + 1;
          if (ap_continue) begin r = mk(0, m_s, m_lat, m_int, 0); have = 1; ended = 1; end
          else begin m_done_seen = 1; m_stall = 1; end
        end
      end else begin
        if (ap_continue) begin r = mk(0, m_s, m_lat, m_int, m_stall); have = 1; ended = 1; end
        else if (m_stall != '1) m_stall = m_stall + 1;
      end
      if (ended) begin
        m_inflight = 0;
        if (can_start) begin_inv();
      end
    end else if (can_start) begin
      begin_inv();
      if (ap_done) begin
        m_lat = 1;
        if (ap_continue) begin r = mk(0, m_s, 1, m_int, 0); have = 1; m_inflight = 0; end
        else begin m_done_seen = 1; m_stall = 1; end
      end
    end
    if (!finish) m_blk = 0;
    if (flushed) m_blk = 1;
    if (have) begin
      if (m_occ < DEPTH || pop) begin exp_q.push_back(r); m_occ++; end
      else begin m_ovf = 1; if (m_drop != '1) m_drop = m_drop + 1; end
    end
    if (pop) m_occ--;
  endtask

  task automatic step(input bit st, dn, ct, fin, en, rdy);
    ap_start = st; ap_done = dn; ap_continue = ct; finish = fin; enable = en;
    rec_ready = rdy; ap_ready = 1'($urandom_range(0, 1));
    model_step();
    @(posedge ap_clk);
    #1;
    cyc = cyc + 1;
  endtask

  task automatic idle_until(input int n, input bit rdy);
    while (cyc < 32'(n)) step(0, 0, 1, 0, 1, rdy);
  endtask

  task automatic chk_got(input string name, input int idx, input prof_rec_t exp);
    if (got_q.size() <= idx) begin
      checks++; errors++;
      $display("FAIL %s: got no record #%0d (only %0d) expected %0h", name, idx, got_q.size(), exp);
    end else check(name, 192'(got_q[idx]), 192'(exp));
  endtask

  always @(negedge ap_clk) begin
    if (mon_en && ap_rst_n) begin
      check("cycle_count", 192'(cycle_count), 192'(cyc));
      check("busy", 192'(busy), 192'(busy_now));
      check("rec_valid", 192'(rec_valid), 192'(occ_now > 0));
      check("overflow", 192'(overflow), 192'(ovf_now));
      check("drop_count", 192'(drop_count), 192'(drop_now));
      if (rec_valid && rec_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rec_pop: got record %0h expected no record", rec_data);
        end else check("rec_data", 192'(rec_data), 192'(exp_q.pop_front()));
        got_q.push_back(rec_data);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int fin_left;
    model_reset();
    repeat (3) @(posedge ap_clk);
    #1;
    check("reset_rec_valid", 192'(rec_valid), 192'(0));
    check("reset_busy", 192'(busy), 192'(0));
    check("reset_rec_data", 192'(rec_data), 192'(0));
    ap_rst_n = 1'b1; cyc = '0; mon_en = 1'b1;

    // single invocation, continue tied high
    idle_until(10, 1);
    step(1, 0, 1, 0, 1, 1);
    idle_until(14, 1);
    check("t1_valid_c14", 192'(rec_valid), 192'(0));
    step(0, 1, 1, 0, 1, 1);
    check("t1_valid_c15", 192'(rec_valid), 192'(1));
    // second invocation
    idle_until(20, 1);
    step(1, 0, 1, 0, 1, 1);
    step(0, 0, 1, 0, 1, 1);
    step(0, 1, 1, 0, 1, 1);
    // continue stall
    idle_until(36, 1);
    step(1, 0, 1, 0, 1, 1);
    idle_until(40, 1);
    step(0, 1, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    check("t3_busy_c43", 192'(busy), 192'(1));
    step(0, 0, 1, 0, 1, 1);
    check("t3_busy_c44", 192'(busy), 192'(0));
    // back-to-back
    idle_until(47, 1);
    step(1, 0, 1, 0, 1, 1);
    idle_until(50, 1);
    step(1, 1, 1, 0, 1, 1);
    idle_until(53, 1);
    step(0, 1, 1, 0, 1, 1);
    idle_until(58, 1);
    chk_got("t1_rec", 0, mk(0, 10, 5, 0, 0));
    chk_got("t2_rec", 1, mk(0, 20, 3, 10, 0));
    chk_got("t3_rec", 2, mk(0, 36, 5, 16, 3));
    chk_got("t4_rec_a", 3, mk(0, 47, 4, 11, 0));
    chk_got("t4_rec_b", 4, mk(0, 50, 4, 3, 0));

    // overflow: six invocations with the consumer stalled
    for (int k = 0; k < 6; k++) begin
      idle_until(60 + 6 * k, 0);
      step(1, 0, 1, 0, 1, 0);
      step(0, 1, 1, 0, 1, 0);
    end
    idle_until(94, 0);
    check("t5_overflow", 192'(overflow), 192'(1));
    check("t5_drop_count", 192'(drop_count), 192'(2));
    check("t5_held_valid", 192'(rec_valid), 192'(1));
    idle_until(100, 1);
    check("t5_drained", 192'(got_q.size()), 192'(9));
    chk_got("t5_rec0", 5, mk(0, 60, 2, 10, 0));
    chk_got("t5_rec1", 6, mk(0, 66, 2, 6, 0));
    chk_got("t5_rec2", 7, mk(0, 72, 2, 6, 0));
    chk_got("t5_rec3", 8, mk(0, 78, 2, 6, 0));

    // finish mid-RUN, then a start ignored while finish is still high
    step(1, 0, 1, 0, 1, 1);
    idle_until(107, 1);
    step(0, 0, 1, 1, 1, 1);
    check("t6_busy_c108", 192'(busy), 192'(0));
    step(1, 0, 1, 1, 1, 1);
    check("t6_start_blocked", 192'(busy), 192'(0));
    idle_until(113, 1);
    chk_got("t6_rec", 9, mk(1, 100, 8, 10, 0));

    // reset mid-RUN with a record queued
    idle_until(115, 0);
    step(1, 0, 1, 0, 1, 0);
    step(0, 1, 1, 0, 1, 0);
    idle_until(120, 0);
    step(1, 0, 1, 0, 1, 0);
    step(0, 0, 1, 0, 1, 0);
    check("t7_pre_valid", 192'(rec_valid), 192'(1));
    check("t7_pre_busy", 192'(busy), 192'(1));
    mon_en = 1'b0;
    #2 ap_rst_n = 1'b0;
    #1;
    check("t7_rst_valid", 192'(rec_valid), 192'(0));
    check("t7_rst_busy", 192'(busy), 192'(0));
    check("t7_rst_cycle", 192'(cycle_count), 192'(0));
    model_reset();
    ap_start = 0; ap_done = 0; finish = 0; rec_ready = 0;
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1; cyc = '0; mon_en = 1'b1;

    // random traffic
    fin_left = 0;
    for (int i = 0; i < 3000; i++) begin
      bit f;
      if (fin_left > 0) begin f = 1; fin_left--; end
      else begin
        f = 0;
        if ($urandom_range(0, 149) == 0) fin_left = int'($urandom_range(1, 4));
      end
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 9) < 7), f, ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 9) < 6));
    end
    repeat (30) step(0, 1, 1, 0, 1, 1);
    check("final_exp_empty", 192'(exp_q.size()), 192'(0));
    check("final_busy", 192'(busy), 192'(0));

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
